// File: rtl/fetch_unit.sv
// Program-counter sequencer for a small in-order core: IDLE/RUN/HALT control,
// registered compare flag for conditional branches, and a saturating RUN-cycle counter.
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             JumpEqual,
    input  logic             JumpNotEqual,
    input  logic             Ack,
    input  logic             FlagWrEn,
    input  logic             Equal,
    input  logic [PC_W-1:0]  TargetAddr,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic             EqFlag,
    output logic [CNT_W-1:0] CycleCount,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              eq_q, eq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              branch_taken;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
        end
    end

    // Branch decision uses the flag as registered, never the same-cycle compare result.
    assign branch_taken = (JumpEqual & eq_q) | (JumpNotEqual & ~eq_q) | (JumpEqual & JumpNotEqual);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    eq_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (FlagWrEn) begin
                    eq_d = Equal;
                end
                // Halt wins over any jump decoded on the same word.
                if (Ack) begin
                    state_d = HALT;
                end else if (branch_taken) begin
                    pc_d = TargetAddr;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        Running    = (state_q == RUN);
        Done       = (state_q == HALT);
        ProgCtr    = pc_q;
        EqFlag     = eq_q;
        CycleCount = cnt_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default instance plus narrow PC and narrow counter instances.
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        JumpEqual;
    logic        JumpNotEqual;
    logic        Ack;
    logic        FlagWrEn;
    logic        Equal;
    logic [9:0]  TargetAddr;

    logic [9:0]  ProgCtr;
    logic        Running;
    logic        Done;
    logic        EqFlag;
    logic [15:0] CycleCount;
    logic [1:0]  state_dbg;

    logic [3:0]  pw_pc;
    logic        pw_running, pw_done, pw_eq;
    logic [15:0] pw_cnt;
    logic [1:0]  pw_state;

    logic [9:0]  cw_pc;
    logic        cw_running, cw_done, cw_eq;
    logic [3:0]  cw_cnt;
    logic [1:0]  cw_state;

    int passed;
    int total;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .JumpEqual(JumpEqual),
        .JumpNotEqual(JumpNotEqual), .Ack(Ack), .FlagWrEn(FlagWrEn), .Equal(Equal),
        .TargetAddr(TargetAddr), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
        .EqFlag(EqFlag), .CycleCount(CycleCount), .state_dbg(state_dbg)
    );

    fetch_unit #(.PC_W(4), .CNT_W(16)) dut_pw (
        .Clk(Clk), .Reset(Reset), .Start(Start), .JumpEqual(JumpEqual),
        .JumpNotEqual(JumpNotEqual), .Ack(Ack), .FlagWrEn(FlagWrEn), .Equal(Equal),
        .TargetAddr(TargetAddr[3:0]), .ProgCtr(pw_pc), .Running(pw_running), .Done(pw_done),
        .EqFlag(pw_eq), .CycleCount(pw_cnt), .state_dbg(pw_state)
    );

    fetch_unit #(.PC_W(10), .CNT_W(4)) dut_cw (
        .Clk(Clk), .Reset(Reset), .Start(Start), .JumpEqual(JumpEqual),
        .JumpNotEqual(JumpNotEqual), .Ack(Ack), .FlagWrEn(FlagWrEn), .Equal(Equal),
        .TargetAddr(TargetAddr), .ProgCtr(cw_pc), .Running(cw_running), .Done(cw_done),
        .EqFlag(cw_eq), .CycleCount(cw_cnt), .state_dbg(cw_state)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        Start = 0; JumpEqual = 0; JumpNotEqual = 0; Ack = 0;
        FlagWrEn = 0; Equal = 0; TargetAddr = '0;
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_dut();
        clear_inputs();
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    task automatic start_dut();
        Start = 1;
        tick();
        Start = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (state_dbg !== S_IDLE) $display("FAIL reset_state got %0d exp %0d", state_dbg, S_IDLE); else passed++;
        total++; if (ProgCtr !== 10'd0) $display("FAIL reset_pc got %0d exp 0", ProgCtr); else passed++;
        total++; if ({Running, Done, EqFlag} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {Running, Done, EqFlag}); else passed++;
        total++; if (CycleCount !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", CycleCount); else passed++;
        tick(); tick();
        total++; if (state_dbg !== S_IDLE || ProgCtr !== 10'd0) $display("FAIL idle_hold got state %0d pc %0d exp state 0 pc 0", state_dbg, ProgCtr); else passed++;
    endtask

    task automatic test_sequential();
        reset_dut();
        start_dut();
        total++; if (ProgCtr !== 10'd0 || Running !== 1'b1) $display("FAIL start_pc got pc %0d run %b exp pc 0 run 1", ProgCtr, Running); else passed++;
        for (int i = 1; i <= 5; i++) begin
            Start = (i == 3); // Start must be ignored while running
            tick();
            total++; if (ProgCtr !== 10'(i)) $display("FAIL seq_pc got %0d exp %0d", ProgCtr, i); else passed++;
        end
        Start = 0;
        total++; if (Running !== 1'b1 || Done !== 1'b0) $display("FAIL seq_running got %b%b exp 10", Running, Done); else passed++;
        total++; if (CycleCount !== 16'd5) $display("FAIL seq_cnt got %0d exp 5", CycleCount); else passed++;
    endtask

    task automatic run_to_pc3_and_set_flag();
        reset_dut();
        start_dut();
        tick(); tick(); tick();
        FlagWrEn = 1; Equal = 1;
        tick();
        FlagWrEn = 0; Equal = 0;
    endtask

    task automatic test_branch();
        run_to_pc3_and_set_flag();
        total++; if (ProgCtr !== 10'd4 || EqFlag !== 1'b1) $display("FAIL flag_set got pc %0d eq %b exp pc 4 eq 1", ProgCtr, EqFlag); else passed++;
        JumpEqual = 1; TargetAddr = 10'd40;
        tick();
        JumpEqual = 0;
        total++; if (ProgCtr !== 10'd40) $display("FAIL je_taken got %0d exp 40", ProgCtr); else passed++;

        run_to_pc3_and_set_flag();
        JumpNotEqual = 1; TargetAddr = 10'd40;
        tick();
        JumpNotEqual = 0;
        total++; if (ProgCtr !== 10'd5) $display("FAIL jne_not_taken got %0d exp 5", ProgCtr); else passed++;

        JumpNotEqual = 1; JumpEqual = 1; TargetAddr = 10'd100;
        tick();
        JumpNotEqual = 0; JumpEqual = 0;
        total++; if (ProgCtr !== 10'd100) $display("FAIL both_jumps got %0d exp 100", ProgCtr); else passed++;
    endtask

    task automatic test_same_cycle_flag();
        reset_dut();
        start_dut();
        FlagWrEn = 1; Equal = 1; JumpEqual = 1; TargetAddr = 10'd40;
        tick();
        clear_inputs();
        total++; if (ProgCtr !== 10'd1) $display("FAIL old_flag_branch got %0d exp 1", ProgCtr); else passed++;
        total++; if (EqFlag !== 1'b1) $display("FAIL flag_after got %b exp 1", EqFlag); else passed++;
    endtask

    task automatic test_ack();
        run_to_pc3_and_set_flag();
        tick(); tick(); tick();
        total++; if (ProgCtr !== 10'd7) $display("FAIL pre_ack_pc got %0d exp 7", ProgCtr); else passed++;
        Ack = 1; JumpEqual = 1; TargetAddr = 10'd40;
        tick();
        clear_inputs();
        total++; if (state_dbg !== S_HALT || ProgCtr !== 10'd7) $display("FAIL halt got state %0d pc %0d exp state 2 pc 7", state_dbg, ProgCtr); else passed++;
        total++; if (Done !== 1'b1 || Running !== 1'b0) $display("FAIL halt_outs got done %b run %b exp done 1 run 0", Done, Running); else passed++;
        total++; if (CycleCount !== 16'd8) $display("FAIL halt_cnt got %0d exp 8", CycleCount); else passed++;
        FlagWrEn = 1; Equal = 0;
        tick();
        clear_inputs();
        total++; if (EqFlag !== 1'b1 || ProgCtr !== 10'd7 || CycleCount !== 16'd8) $display("FAIL halt_hold got eq %b pc %0d cnt %0d exp eq 1 pc 7 cnt 8", EqFlag, ProgCtr, CycleCount); else passed++;
        start_dut();
        total++; if (ProgCtr !== 10'd0 || CycleCount !== 16'd0 || Running !== 1'b1 || EqFlag !== 1'b0) $display("FAIL restart got pc %0d cnt %0d run %b eq %b exp pc 0 cnt 0 run 1 eq 0", ProgCtr, CycleCount, Running, EqFlag); else passed++;
    endtask

    task automatic test_mid_run_reset();
        reset_dut();
        start_dut();
        tick(); tick();
        FlagWrEn = 1; Equal = 1;
        tick();
        clear_inputs();
        for (int i = 0; i < 6; i++) tick();
        total++; if (ProgCtr !== 10'd9 || EqFlag !== 1'b1) $display("FAIL pre_reset got pc %0d eq %b exp pc 9 eq 1", ProgCtr, EqFlag); else passed++;
        Reset = 1; Start = 1;
        tick();
        Reset = 0; Start = 0;
        total++; if (state_dbg !== S_IDLE || ProgCtr !== 10'd0) $display("FAIL midrun_reset got state %0d pc %0d exp state 0 pc 0", state_dbg, ProgCtr); else passed++;
        total++; if (EqFlag !== 1'b0 || CycleCount !== 16'd0 || Running !== 1'b0) $display("FAIL midrun_reset_regs got eq %b cnt %0d run %b exp 0 0 0", EqFlag, CycleCount, Running); else passed++;
        tick();
        total++; if (state_dbg !== S_IDLE) $display("FAIL post_reset_idle got %0d exp 0", state_dbg); else passed++;
    endtask

    task automatic test_wrap_saturate();
        reset_dut();
        start_dut();
        for (int i = 0; i < 15; i++) tick();
        total++; if (pw_pc !== 4'd15) $display("FAIL narrow_pc_top got %0d exp 15", pw_pc); else passed++;
        total++; if (cw_cnt !== 4'd15) $display("FAIL narrow_cnt_top got %0d exp 15", cw_cnt); else passed++;
        tick();
        total++; if (pw_pc !== 4'd0 || pw_running !== 1'b1) $display("FAIL pc_wrap got pc %0d run %b exp pc 0 run 1", pw_pc, pw_running); else passed++;
        for (int i = 0; i < 4; i++) tick();
        total++; if (cw_cnt !== 4'd15) $display("FAIL cnt_saturate got %0d exp 15", cw_cnt); else passed++;
        total++; if (CycleCount !== 16'd20) $display("FAIL wide_cnt got %0d exp 20", CycleCount); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        Reset  = 1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_same_cycle_flag();
        test_ack();
        test_mid_run_reset();
        test_wrap_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
